// File: rtl/worldclean_pkg.sv
// Shared definitions for the playfield objects (target, bullet, ship).
//   state_e      : life cycle of a spawned object (WAIT -> ALIVE -> EXPLODE)
//   H_ACTIVE/V_ACTIVE : visible screen size in pixels
//   LFSR_SEED/LFSR_TAPS and lfsr8_next() : 8-bit Fibonacci LFSR used for spawn rows
package worldclean_pkg;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    ALIVE   = 2'd1,
    EXPLODE = 2'd2
  } state_e;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 -> bits 7,5,4,3 (maximal length, never reaches all-zero)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/trash_target_if.sv
// Pixel/bullet bus between the scan logic and the trash target.
//   v_sync, pix_x, pix_y, bullet_on : scan position and bullet draw signal
//   target_on, hit, miss, bullet_kill, score : target results
// master = scan/shot side, slave = the target block.
interface trash_target_if;
  logic       v_sync;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       bullet_on;
  logic       target_on;
  logic       hit;
  logic       miss;
  logic       bullet_kill;
  logic [7:0] score;

  modport master (
    output v_sync, pix_x, pix_y, bullet_on,
    input  target_on, hit, miss, bullet_kill, score
  );

  modport slave (
    input  v_sync, pix_x, pix_y, bullet_on,
    output target_on, hit, miss, bullet_kill, score
  );
endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, advances every clk.
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads LFSR_SEED
//   value : current LFSR contents
module lfsr8
  import worldclean_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] value
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr8_next(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/trash_target.sv
// Trash target: spawns at the right edge, drifts left once per frame,
// explodes when the bullet overlaps it, keeps a saturating hit score.
//   clk   : pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : trash_target_if.slave (v_sync, pix_x/y, bullet_on in;
//           target_on, hit, miss, bullet_kill, score out)
// Optional build macro: EXPLODE_FLASH_EN -- debris box flashes on
// alternate frames while exploding.
module trash_target
  import worldclean_pkg::*;
#(
  parameter int T_SIZE         = 16,
  parameter int T_SPEED        = 4,
  parameter int SPAWN_X        = H_ACTIVE - T_SIZE,
  parameter int Y_MIN          = 40,
  parameter int EXPLODE_FRAMES = 8,
  parameter int RESPAWN_FRAMES = 30
) (
  input logic         clk,
  input logic         rst_n,
  trash_target_if.slave bus
);

  localparam int CNT_MAX = (RESPAWN_FRAMES > EXPLODE_FRAMES) ? RESPAWN_FRAMES : EXPLODE_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       t_x_q, t_x_d;
  logic [9:0]       t_y_q, t_y_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;
  logic             kill_q, kill_d;
  logic [7:0]       score_q, score_d;
  logic             v_sync_q;
`ifdef EXPLODE_FLASH_EN
  logic             parity_q, parity_d;
`endif

  logic [7:0]  lfsr_val;
  logic        frame_tick;
  logic [10:0] x_lo, x_hi, y_lo, y_hi, px_w, py_w;
  logic        in_box;
  logic        collide;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .value(lfsr_val)
  );

  // Box bounds in 11 bits so t_x + T_SIZE never wraps at the screen edge
  always_comb begin
    frame_tick = bus.v_sync && !v_sync_q;
    x_lo   = {1'b0, t_x_q};
    y_lo   = {1'b0, t_y_q};
    x_hi   = x_lo + 11'(T_SIZE);
    y_hi   = y_lo + 11'(T_SIZE);
    px_w   = {1'b0, bus.pix_x};
    py_w   = {1'b0, bus.pix_y};
    in_box = (px_w >= x_lo) && (px_w < x_hi) && (py_w >= y_lo) && (py_w < y_hi);
    collide = (state_q == ALIVE) && bus.bullet_on && in_box;
  end

`ifdef EXPLODE_FLASH_EN
  assign bus.target_on = in_box && ((state_q == ALIVE) || ((state_q == EXPLODE) && parity_q));
`else
  assign bus.target_on = in_box && (state_q == ALIVE);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_x_d   = t_x_q;
    t_y_d   = t_y_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    score_d = score_q;
    // A pending kill lasts until the next frame; a new collision re-arms it below
    kill_d  = frame_tick ? 1'b0 : kill_q;
`ifdef EXPLODE_FLASH_EN
    parity_d = parity_q;
`endif

    case (state_q)
      WAIT: begin
        if (frame_tick) begin
          if (cnt_q == CNT_W'(RESPAWN_FRAMES - 1)) begin
            state_d = ALIVE;
            cnt_d   = '0;
            t_x_d   = 10'(SPAWN_X);
            t_y_d   = 10'(Y_MIN) + {2'b00, lfsr_val};
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ALIVE: begin
        // Collision has priority over the frame move/miss in the same clk
        if (collide) begin
          state_d = EXPLODE;
          hit_d   = 1'b1;
          kill_d  = 1'b1;
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
`ifdef EXPLODE_FLASH_EN
          parity_d = 1'b0;
`endif
        end else if (frame_tick) begin
          if (t_x_q < 10'(T_SPEED)) begin
            miss_d  = 1'b1;
            state_d = WAIT;
          end else begin
            t_x_d = t_x_q - 10'(T_SPEED);
          end
        end
      end

      EXPLODE: begin
        if (frame_tick) begin
`ifdef EXPLODE_FLASH_EN
          parity_d = !parity_q;
`endif
          if (cnt_q == CNT_W'(EXPLODE_FRAMES - 1)) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT;
      cnt_q    <= '0;
      t_x_q    <= 10'(SPAWN_X);
      t_y_q    <= 10'(Y_MIN);
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      kill_q   <= 1'b0;
      score_q  <= 8'd0;
      v_sync_q <= 1'b0;
`ifdef EXPLODE_FLASH_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      t_x_q    <= t_x_d;
      t_y_q    <= t_y_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      kill_q   <= kill_d;
      score_q  <= score_d;
      v_sync_q <= bus.v_sync;
`ifdef EXPLODE_FLASH_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.hit         = hit_q;
  assign bus.miss        = miss_q;
  assign bus.bullet_kill = kill_q;
  assign bus.score       = score_q;

endmodule

// File: tb/tb_trash_target.sv
// Self-checking bench for trash_target: a frame-level behavioural model
// tracks phase, position and score; every clk the DUT outputs are compared
// with the model, plus a table of box-boundary probes and directed sequences.
module tb_trash_target;

  localparam int T_SIZE         = 16;
  localparam int T_SPEED        = 4;
  localparam int SPAWN_X        = 624;
  localparam int Y_MIN          = 40;
  localparam int EXPLODE_FRAMES = 8;
  localparam int RESPAWN_FRAMES = 30;
  localparam int PH_WAIT        = 0;
  localparam int PH_ALIVE       = 1;
  localparam int PH_BOOM        = 2;
`ifdef EXPLODE_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  trash_target_if bus_if ();

  trash_target dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  typedef struct {
    int dx;
    int dy;
    bit exp_on;
  } probe_t;
  probe_t probes [10];

  int total = 0;
  int bad = 0;
  int hit_count = 0;

  // behavioural model
  int         m_phase, m_frames, m_x, m_y, m_score;
  bit         m_hit, m_miss, m_kill, m_vsq, m_par;
  logic [7:0] m_lfsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit m_on(input int px, input int py);
    bit in_box;
    in_box = (px >= m_x) && (px < m_x + T_SIZE) && (py >= m_y) && (py < m_y + T_SIZE);
    return in_box && ((m_phase == PH_ALIVE) || (FLASH && (m_phase == PH_BOOM) && m_par));
  endfunction

  task automatic model_reset();
    m_phase  = PH_WAIT;
    m_frames = 0;
    m_x      = SPAWN_X;
    m_y      = Y_MIN;
    m_score  = 0;
    m_hit    = 1'b0;
    m_miss   = 1'b0;
    m_kill   = 1'b0;
    m_vsq    = 1'b0;
    m_par    = 1'b0;
    m_lfsr   = 8'hA5;
  endtask

  task automatic model_step(input bit vs, input int px, input int py, input bit bo);
    bit         ft;
    bit         on;
    logic [7:0] nl;
    ft = vs && !m_vsq;
    on = m_on(px, py);
    nl = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    m_hit  = 1'b0;
    m_miss = 1'b0;
    if (m_phase == PH_ALIVE && bo && on) begin
      m_phase  = PH_BOOM;
      m_frames = 0;
      m_hit    = 1'b1;
      m_kill   = 1'b1;
      m_par    = 1'b0;
      m_score  = (m_score >= 255) ? 255 : m_score + 1;
    end else if (ft) begin
      m_kill = 1'b0;
      case (m_phase)
        PH_WAIT: begin
          m_frames++;
          if (m_frames == RESPAWN_FRAMES) begin
            m_phase  = PH_ALIVE;
            m_frames = 0;
            m_x      = SPAWN_X;
            m_y      = Y_MIN + int'(m_lfsr);
          end
        end
        PH_ALIVE: begin
          if (m_x < T_SPEED) begin
            m_miss  = 1'b1;
            m_phase = PH_WAIT;
          end else begin
            m_x = m_x - T_SPEED;
          end
        end
        default: begin
          m_par = !m_par;
          m_frames++;
          if (m_frames == EXPLODE_FRAMES) begin
            m_phase  = PH_WAIT;
            m_frames = 0;
          end
        end
      endcase
    end
    m_vsq  = vs;
    m_lfsr = nl;
  endtask

  // One clk: drive at negedge, compare #1 after the posedge, return at negedge
  task automatic cycle(input bit vs, input int px, input int py, input bit bo);
    int          pxw, pyw;
    logic [11:0] exp_v, act_v;
    pxw = px & 1023;
    pyw = py & 1023;
    bus_if.v_sync    = vs;
    bus_if.pix_x     = pxw[9:0];
    bus_if.pix_y     = pyw[9:0];
    bus_if.bullet_on = bo;
    model_step(vs, pxw, pyw, bo);
    @(posedge clk);
    #1;
    if (bus_if.hit === 1'b1) hit_count++;
    exp_v = {m_on(pxw, pyw), m_hit, m_miss, m_kill, m_score[7:0]};
    act_v = {bus_if.target_on, bus_if.hit, bus_if.miss, bus_if.bullet_kill, bus_if.score};
    check("cycle{on,hit,miss,kill,score}", 32'(act_v), 32'(exp_v));
    @(negedge clk);
  endtask

  task automatic rand_cycle(input bit vs, input bit rnd_bullet);
    int px, py;
    bit rb;
    px = m_x - 8 + int'($urandom_range(0, 32));
    py = m_y - 8 + int'($urandom_range(0, 32));
    rb = rnd_bullet && (m_phase != PH_ALIVE) && ($urandom_range(0, 1) == 1);
    cycle(vs, px, py, rb);
  endtask

  task automatic frames(input int n, input bit rnd_bullet);
    for (int i = 0; i < n; i++) begin
      rand_cycle(1'b1, rnd_bullet);
      rand_cycle(1'b0, rnd_bullet);
    end
  endtask

  task automatic wait_alive();
    int guard;
    guard = 0;
    while (m_phase != PH_ALIVE && guard < 100) begin
      frames(1, 1'b1);
      guard++;
    end
    check("wait_alive_bound", 32'(m_phase), 32'(PH_ALIVE));
  endtask

  task automatic apply_probes(input string tag);
    int bx, by;
    bx = m_x;
    by = m_y;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, bx + probes[i].dx, by + probes[i].dy, 1'b0);
      check($sformatf("probe_%s_%0d", tag, i), 32'(bus_if.target_on), 32'(probes[i].exp_on));
    end
  endtask

  initial begin
    int bx, by, guard;
    probes[0] = '{0, 0, 1'b1};
    probes[1] = '{15, 15, 1'b1};
    probes[2] = '{3, 5, 1'b1};
    probes[3] = '{-1, 0, 1'b0};
    probes[4] = '{16, 0, 1'b0};
    probes[5] = '{0, -1, 1'b0};
    probes[6] = '{0, 16, 1'b0};
    probes[7] = '{15, 16, 1'b0};
    probes[8] = '{16, 15, 1'b0};
    probes[9] = '{7, -1, 1'b0};

    // reset
    rst_n = 1'b0;
    bus_if.v_sync    = 1'b0;
    bus_if.pix_x     = 10'd624;
    bus_if.pix_y     = 10'd40;
    bus_if.bullet_on = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_hit", 32'(bus_if.hit), 32'd0);
    check("reset_miss", 32'(bus_if.miss), 32'd0);
    check("reset_kill", 32'(bus_if.bullet_kill), 32'd0);
    check("reset_score", 32'(bus_if.score), 32'd0);
    check("reset_target_on", 32'(bus_if.target_on), 32'd0);
    rst_n = 1'b1;

    // spawn after RESPAWN_FRAMES ticks
    frames(RESPAWN_FRAMES - 1, 1'b1);
    cycle(1'b0, SPAWN_X + 3, Y_MIN + 5, 1'b0);
    check("pre_spawn_off", 32'(bus_if.target_on), 32'd0);
    frames(1, 1'b1);
    apply_probes("spawn");

    // drift left, then miss off the left edge
    frames(1, 1'b0);
    cycle(1'b0, 620, m_y, 1'b0);
    check("drift_620_on", 32'(bus_if.target_on), 32'd1);
    cycle(1'b0, 619, m_y, 1'b0);
    check("drift_619_off", 32'(bus_if.target_on), 32'd0);
    cycle(1'b0, 635, m_y + 15, 1'b0);
    check("drift_635_on", 32'(bus_if.target_on), 32'd1);
    cycle(1'b0, 636, m_y + 15, 1'b0);
    check("drift_636_off", 32'(bus_if.target_on), 32'd0);
    frames(155, 1'b0);
    apply_probes("x0");
    cycle(1'b1, 5, 5, 1'b0);
    check("miss_pulse", 32'(bus_if.miss), 32'd1);
    check("miss_score", 32'(bus_if.score), 32'd0);
    cycle(1'b0, 5, 5, 1'b0);
    check("miss_one_clk", 32'(bus_if.miss), 32'd0);

    // single hit, kill held until next frame tick
    frames(RESPAWN_FRAMES, 1'b1);
    bx = m_x;
    by = m_y;
    cycle(1'b0, bx + 3, by + 5, 1'b1);
    check("hit_pulse", 32'(bus_if.hit), 32'd1);
    check("hit_score", 32'(bus_if.score), 32'd1);
    check("hit_kill", 32'(bus_if.bullet_kill), 32'd1);
    check("hit_target_off", 32'(bus_if.target_on), 32'd0);
    cycle(1'b0, bx + 3, by + 5, 1'b1);
    check("hit_one_clk", 32'(bus_if.hit), 32'd0);
    check("hit_no_double", 32'(bus_if.score), 32'd1);
    repeat (4) rand_cycle(1'b0, 1'b1);
    check("kill_held", 32'(bus_if.bullet_kill), 32'd1);
    rand_cycle(1'b1, 1'b1);
    check("kill_clear", 32'(bus_if.bullet_kill), 32'd0);

    // bullet over the whole box in one frame -> single hit
    wait_alive();
    bx = m_x;
    by = m_y;
    hit_count = 0;
    for (int dy = 0; dy < T_SIZE; dy++)
      for (int dx = 0; dx < T_SIZE; dx++)
        cycle(1'b0, bx + dx, by + dy, 1'b1);
    check("scan_hits", 32'(hit_count), 32'd1);
    check("scan_score", 32'(bus_if.score), 32'd2);

    // collision on the frame tick at x=0: collision wins, no miss
    wait_alive();
    frames(156, 1'b0);
    cycle(1'b0, m_x, m_y, 1'b0);
    check("edge_x0_on", 32'(bus_if.target_on), 32'd1);
    cycle(1'b1, m_x + 3, m_y + 5, 1'b1);
    check("tick_collide_hit", 32'(bus_if.hit), 32'd1);
    check("tick_collide_no_miss", 32'(bus_if.miss), 32'd0);
    check("tick_collide_score", 32'(bus_if.score), 32'd3);
    cycle(1'b0, 0, 0, 1'b0);
    check("tick_collide_no_late_miss", 32'(bus_if.miss), 32'd0);

    // saturate the score with randomized hit positions
    guard = 0;
    while (m_score < 255 && guard < 400) begin
      wait_alive();
      frames(int'($urandom_range(0, 3)), 1'b0);
      cycle(1'b0, m_x + int'($urandom_range(0, 15)), m_y + int'($urandom_range(0, 15)), 1'b1);
      guard++;
    end
    check("sat_reach", 32'(bus_if.score), 32'd255);
    wait_alive();
    cycle(1'b0, m_x + 7, m_y + 7, 1'b1);
    check("sat_hit", 32'(bus_if.hit), 32'd1);
    check("sat_hold", 32'(bus_if.score), 32'd255);

    // async reset mid-EXPLODE
    frames(3, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_hit", 32'(bus_if.hit), 32'd0);
    check("rst_miss", 32'(bus_if.miss), 32'd0);
    check("rst_kill", 32'(bus_if.bullet_kill), 32'd0);
    check("rst_score", 32'(bus_if.score), 32'd0);
    check("rst_target_on", 32'(bus_if.target_on), 32'd0);
    model_reset();
    bus_if.v_sync    = 1'b0;
    bus_if.bullet_on = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    frames(RESPAWN_FRAMES - 1, 1'b1);
    cycle(1'b0, SPAWN_X + 3, Y_MIN + 5, 1'b0);
    check("post_rst_wait_off", 32'(bus_if.target_on), 32'd0);
    frames(1, 1'b1);
    apply_probes("respawn");
    check("respawn_score", 32'(bus_if.score), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/trash_target.md
Name: trash_target

Overview:
Target ("trash") object at the receiving end of the ship's shot.
- Spawns at the right edge and drifts left once per frame.
- Detects pixel-level overlap with the bullet's draw signal, then explodes and tells the shot logic to retire the bullet.
- Counts hits into a saturating score and respawns at a pseudo-random row.
- Sits beside the bullet and ship blocks; its target_on feeds the pixel colour mux.

Parameters:
T_SIZE, 16, target square side in pixels
T_SPEED, 4, leftward pixels per frame
SPAWN_X, 624, x of left edge at spawn
Y_MIN, 40, top row offset for spawn y
EXPLODE_FRAMES, 8, frames spent in EXPLODE
RESPAWN_FRAMES, 30, frames spent in WAIT before spawning

Ports:
clk  in  1  pixel clock, single clock domain
rst_n  in  1  asynchronous active-low reset
v_sync  in  1  vertical sync from VGA timing, sampled in clk domain
pix_x  in  10  current scan x
pix_y  in  10  current scan y
bullet_on  in  1  bullet draw signal for the current pixel
target_on  out  1  target covers current pixel (combinational from registers and pix_x/pix_y)
hit  out  1  one-clk pulse on collision
miss  out  1  one-clk pulse when target leaves the left edge
bullet_kill  out  1  level: bullet must retire; held until next frame tick
score  out  8  saturating hit count

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state=WAIT, frame counter=0, t_x=SPAWN_X, t_y=Y_MIN.
  - hit=0, miss=0, bullet_kill=0, score=0.
  - LFSR=8'hA5; v_sync_q=0.
- frame_tick: v_sync && !v_sync_q, with v_sync_q registered every clk. One pulse per rising edge of v_sync.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances every clk, never all-zero.
- States:
  - WAIT: count frame_ticks. On the RESPAWN_FRAMES-th tick go to ALIVE, with t_x=SPAWN_X, t_y=Y_MIN+{2'b0,LFSR}, counter cleared.
  - ALIVE: on frame_tick, if t_x < T_SPEED, assert miss for 1 clk and go to WAIT. Otherwise t_x <= t_x - T_SPEED.
  - ALIVE collision: bullet_on && target_on in the same clk means go to EXPLODE. On the next clk:
    - hit=1 for one clk;
    - score+1, saturating at 255;
    - bullet_kill=1.
  - EXPLODE: count frame_ticks. On the EXPLODE_FRAMES-th tick go to WAIT, counter cleared.
- bullet_kill clears on the first frame_tick after it is set, whatever the state.
- target_on = (state==ALIVE) && pix_x in [t_x, t_x+T_SIZE) && pix_y in [t_y, t_y+T_SIZE). Compute bounds in 11 bits, so no wrap at the 640/480 edges.
- Edge cases:
  - Collision and frame_tick in the same clk: collision wins; no move, no miss.
  - Multiple overlapping pixels in one frame: exactly one hit, because the state has already left ALIVE.
  - bullet_on without target_on, or in WAIT/EXPLODE: ignored.
  - Async reset in any state: returns immediately to reset values; score is lost.

Optional Feature:
EXPLODE_FLASH_EN
- Defined: a frame-parity bit toggles on every frame_tick while in EXPLODE. target_on is asserted over the frozen box when parity=1, giving a flashing debris effect. Collisions are never detected outside ALIVE.
- Undefined: target_on=0 outside ALIVE; no parity register.

Decomposition:
- Shared package worldclean_pkg holds:
  - state typedef {WAIT, ALIVE, EXPLODE};
  - screen constants H_ACTIVE=640, V_ACTIVE=480;
  - LFSR seed 8'hA5 and tap mask.
- Natural sub-module: lfsr8, a free-running 8-bit LFSR with async reset to seed. It can be reused by later spawners.

Test Plan:
- Reset, then 30 v_sync rising edges -> state ALIVE, t_x=624, t_y=40+LFSR value at spawn; no hit or miss pulses.
- ALIVE, one frame_tick -> t_x=620; after 156 ticks t_x=0; 157th tick -> miss pulses 1 clk, state WAIT, score unchanged.
- Scan pixel (t_x+3, t_y+5) with bullet_on=1 -> hit high exactly 1 clk later; score=1; bullet_kill=1 until next frame_tick; target_on=0.
- bullet_on held over the whole 16x16 box in one frame -> single hit pulse, score increments by 1 only.
- Score preloaded to 255 via 255 hits, then another hit -> hit pulses, score stays 255.
- Collision on the same clk as frame_tick -> hit asserted, t_x unchanged. Separately, assert rst_n=0 mid-EXPLODE -> all outputs 0 immediately, WAIT after release.
